rca_config_bank: RTL and testbench



---
 rtl/rca_config_bank.sv | 225 ++++++++++++++++++++++
 tb/tb_rca_config_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_config_bank.sv
// rca_config_bank
//   Double-buffered configuration store for the reconfigurable custom
//   accelerators. Each RCA slot owns a shadow copy, which decode/issue
//   fills entry by entry, and an active copy, which the issue stage reads.
//   A commit command moves shadow into active, but only while that RCA has
//   no use instructions in flight; otherwise the commit is parked as pending
//   and the copy happens on the first cycle the RCA goes idle.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   cfg_valid/ready   command handshake (ready drops only for an RCA whose
//                     commit is still pending)
//   cfg_rca/type/addr/data
//                     command target, kind (0 src, 1 dest, 2 grid mux,
//                     3 IO mux, 4 result mux, 5 IO use, 6 commit, 7 reserved),
//                     entry index and LSB-aligned payload
//   rca_busy          per-RCA "use instructions in flight"
//   rd_valid, rd_rca  read request for one RCA's active configuration
//   rd_out_valid, rd_* registered read data, one cycle after the request
//   commit_pending    per-RCA commit waiting for busy to drop
//   commit_done       one-cycle pulse after any shadow-to-active copy
//   cfg_err           one-cycle pulse after an illegal command was accepted
module rca_config_bank #(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 5,
  parameter int NUM_WRITE_PORTS    = 2,
  parameter int NUM_GRID_MUXES     = 16,
  parameter int GRID_MUX_INPUTS    = 8,
  parameter int GRID_NUM_ROWS      = 4,
  parameter int IO_UNIT_MUX_INPUTS = 8,
  localparam int RCW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int GW  = (GRID_MUX_INPUTS > 1) ? $clog2(GRID_MUX_INPUTS) : 1,
  localparam int RW  = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1,
  localparam int IW  = (IO_UNIT_MUX_INPUTS > 1) ? $clog2(IO_UNIT_MUX_INPUTS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [RCW-1:0]                       cfg_rca,
  input  logic [2:0]                           cfg_type,
  input  logic [7:0]                           cfg_addr,
  input  logic [7:0]                           cfg_data,
  input  logic [NUM_RCAS-1:0]                  rca_busy,
  input  logic                                 rd_valid,
  input  logic [RCW-1:0]                       rd_rca,
  output logic                                 rd_out_valid,
  output logic [5*NUM_READ_PORTS-1:0]          rd_src_addrs,
  output logic [5*NUM_WRITE_PORTS-1:0]         rd_dest_addrs,
  output logic [NUM_GRID_MUXES*GW-1:0]         rd_grid_sel,
  output logic [GRID_NUM_ROWS*IW-1:0]          rd_io_sel,
  output logic [NUM_WRITE_PORTS*RW-1:0]        rd_result_sel,
  output logic [GRID_NUM_ROWS-1:0]             rd_io_use,
  output logic [NUM_RCAS-1:0]                  commit_pending,
  output logic                                 commit_done,
  output logic                                 cfg_err
);

  localparam int SRC_W = 5 * NUM_READ_PORTS;
  localparam int DST_W = 5 * NUM_WRITE_PORTS;
  localparam int GRD_W = NUM_GRID_MUXES * GW;
  localparam int IOS_W = GRID_NUM_ROWS * IW;
  localparam int RES_W = NUM_WRITE_PORTS * RW;
  localparam int USE_W = GRID_NUM_ROWS;

  localparam logic [2:0] T_SRC    = 3'd0;
  localparam logic [2:0] T_DST    = 3'd1;
  localparam logic [2:0] T_GRID   = 3'd2;
  localparam logic [2:0] T_IO     = 3'd3;
  localparam logic [2:0] T_RES    = 3'd4;
  localparam logic [2:0] T_USE    = 3'd5;
  localparam logic [2:0] T_COMMIT = 3'd6;

  // Shadow and active copies, one packed vector per field per RCA.
  logic [SRC_W-1:0] src_sh  [NUM_RCAS];
  logic [SRC_W-1:0] src_act [NUM_RCAS];
  logic [DST_W-1:0] dst_sh  [NUM_RCAS];
  logic [DST_W-1:0] dst_act [NUM_RCAS];
  logic [GRD_W-1:0] grd_sh  [NUM_RCAS];
  logic [GRD_W-1:0] grd_act [NUM_RCAS];
  logic [IOS_W-1:0] ios_sh  [NUM_RCAS];
  logic [IOS_W-1:0] ios_act [NUM_RCAS];
  logic [RES_W-1:0] res_sh  [NUM_RCAS];
  logic [RES_W-1:0] res_act [NUM_RCAS];
  logic [USE_W-1:0] use_sh  [NUM_RCAS];
  logic [USE_W-1:0] use_act [NUM_RCAS];

  logic [NUM_RCAS-1:0] pend_q;
  logic [NUM_RCAS-1:0] commit_hit;
  logic [NUM_RCAS-1:0] copy_now;
  logic [NUM_RCAS-1:0] pend_d;
  logic                accept_p0;
  logic                addr_ok_p0;
  logic                wr_en_p0;
  logic                err_p0;

  logic [SRC_W-1:0]    src_p1;
  logic [DST_W-1:0]    dst_p1;
  logic [GRD_W-1:0]    grd_p1;
  logic [IOS_W-1:0]    ios_p1;
  logic [RES_W-1:0]    res_p1;
  logic [USE_W-1:0]    use_p1;
  logic                vld_p1;
  logic                done_p1;
  logic                err_p1;

  // Payload bits above a field's width are dropped by design.
  logic unused_cfg_data;
  assign unused_cfg_data = ^cfg_data;

  // A pending commit blocks only its own RCA; other slots keep streaming.
  assign cfg_ready = !pend_q[cfg_rca];

  // Stage p0: command decode and commit arbitration
  always_comb begin
    accept_p0  = cfg_valid && cfg_ready;
    addr_ok_p0 = 1'b0;
    case (cfg_type)
      T_SRC:   addr_ok_p0 = int'(cfg_addr) < NUM_READ_PORTS;
      T_DST:   addr_ok_p0 = int'(cfg_addr) < NUM_WRITE_PORTS;
      T_GRID:  addr_ok_p0 = int'(cfg_addr) < NUM_GRID_MUXES;
      T_IO:    addr_ok_p0 = int'(cfg_addr) < GRID_NUM_ROWS;
      T_RES:   addr_ok_p0 = int'(cfg_addr) < NUM_WRITE_PORTS;
      T_USE:   addr_ok_p0 = (cfg_addr == 8'd0);
      default: addr_ok_p0 = 1'b0;
    endcase
    wr_en_p0 = accept_p0 && addr_ok_p0;
    // Commit is legal with any addr/data; everything else that misses its
    // range (including the reserved type) is swallowed and flagged.
    err_p0   = accept_p0 && !addr_ok_p0 && (cfg_type != T_COMMIT);

    commit_hit = '0;
    if (accept_p0 && (cfg_type == T_COMMIT)) commit_hit[cfg_rca] = 1'b1;
    // A requested commit (new or parked) copies as soon as its RCA is idle,
    // otherwise it stays parked. Several RCAs can copy on the same edge.
    copy_now = (pend_q | commit_hit) & ~rca_busy;
    pend_d   = (pend_q | commit_hit) & rca_busy;
  end

  // Configuration storage: shadow writes and shadow-to-active copies.
  // A copying RCA can never be written on the same edge: an immediate
  // commit is itself the accepted command, and a parked one stalls writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        src_sh[i]  <= '0;
        src_act[i] <= '0;
        dst_sh[i]  <= '0;
        dst_act[i] <= '0;
        grd_sh[i]  <= '0;
        grd_act[i] <= '0;
        ios_sh[i]  <= '0;
        ios_act[i] <= '0;
        res_sh[i]  <= '0;
        res_act[i] <= '0;
        use_sh[i]  <= '0;
        use_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        if (copy_now[i]) begin
          src_act[i] <= src_sh[i];
          dst_act[i] <= dst_sh[i];
          grd_act[i] <= grd_sh[i];
          ios_act[i] <= ios_sh[i];
          res_act[i] <= res_sh[i];
          use_act[i] <= use_sh[i];
        end
      end
      if (wr_en_p0) begin
        case (cfg_type)
          T_SRC:   src_sh[cfg_rca][int'(cfg_addr)*5 +: 5]   <= cfg_data[4:0];
          T_DST:   dst_sh[cfg_rca][int'(cfg_addr)*5 +: 5]   <= cfg_data[4:0];
          T_GRID:  grd_sh[cfg_rca][int'(cfg_addr)*GW +: GW] <= cfg_data[GW-1:0];
          T_IO:    ios_sh[cfg_rca][int'(cfg_addr)*IW +: IW] <= cfg_data[IW-1:0];
          T_RES:   res_sh[cfg_rca][int'(cfg_addr)*RW +: RW] <= cfg_data[RW-1:0];
          T_USE:   use_sh[cfg_rca]                          <= cfg_data[USE_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Stage p1: commit/error status and registered read of the active copy.
  // The read samples active before any copy on the same edge lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      src_p1  <= '0;
      dst_p1  <= '0;
      grd_p1  <= '0;
      ios_p1  <= '0;
      res_p1  <= '0;
      use_p1  <= '0;
    end else begin
      pend_q  <= pend_d;
      done_p1 <= |copy_now;
      err_p1  <= err_p0;
      vld_p1  <= rd_valid;
      if (rd_valid) begin
        src_p1 <= src_act[rd_rca];
        dst_p1 <= dst_act[rd_rca];
        grd_p1 <= grd_act[rd_rca];
        ios_p1 <= ios_act[rd_rca];
        res_p1 <= res_act[rd_rca];
        use_p1 <= use_act[rd_rca];
      end
    end
  end

  assign commit_pending = pend_q;
  assign commit_done    = done_p1;
  assign cfg_err        = err_p1;
  assign rd_out_valid   = vld_p1;
  assign rd_src_addrs   = src_p1;
  assign rd_dest_addrs  = dst_p1;
  assign rd_grid_sel    = grd_p1;
  assign rd_io_sel      = ios_p1;
  assign rd_result_sel  = res_p1;
  assign rd_io_use      = use_p1;

endmodule

// File: tb/tb_rca_config_bank.sv
// Testbench for rca_config_bank: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the shadow/active configuration store.
module tb_rca_config_bank;

  localparam int NR    = 4;
  localparam int NRP   = 5;
  localparam int NWP   = 2;
  localparam int NGM   = 16;
  localparam int NROWS = 4;
  localparam int GW    = 3;
  localparam int RW    = 2;
  localparam int IW    = 3;
  localparam int NENT[6] = '{NRP, NWP, NGM, NROWS, NWP, 1};
  localparam int WID[6]  = '{5, 5, GW, IW, RW, NROWS};

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_rca = '0;
  logic [2:0]          cfg_type = '0;
  logic [7:0]          cfg_addr = '0;
  logic [7:0]          cfg_data = '0;
  logic [NR-1:0]       rca_busy = '0;
  logic                rd_valid = 1'b0;
  logic [1:0]          rd_rca = '0;
  logic                rd_out_valid;
  logic [5*NRP-1:0]    rd_src_addrs;
  logic [5*NWP-1:0]    rd_dest_addrs;
  logic [NGM*GW-1:0]   rd_grid_sel;
  logic [NROWS*IW-1:0] rd_io_sel;
  logic [NWP*RW-1:0]   rd_result_sel;
  logic [NROWS-1:0]    rd_io_use;
  logic [NR-1:0]       commit_pending;
  logic                commit_done;
  logic                cfg_err;

  rca_config_bank dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rca(cfg_rca),
    .cfg_type(cfg_type), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rca_busy(rca_busy), .rd_valid(rd_valid), .rd_rca(rd_rca),
    .rd_out_valid(rd_out_valid), .rd_src_addrs(rd_src_addrs),
    .rd_dest_addrs(rd_dest_addrs), .rd_grid_sel(rd_grid_sel),
    .rd_io_sel(rd_io_sel), .rd_result_sel(rd_result_sel),
    .rd_io_use(rd_io_use), .commit_pending(commit_pending),
    .commit_done(commit_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          sh  [NR][6][16];
  int          act [NR][6][16];
  int          rdo [6][16];
  logic [NR-1:0] m_pend;
  int          e_vld, e_done, e_err;

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int f = 0; f < 6; f++)
        for (int e = 0; e < 16; e++) begin
          sh[r][f][e]  = 0;
          act[r][f][e] = 0;
        end
    for (int f = 0; f < 6; f++)
      for (int e = 0; e < 16; e++) rdo[f][e] = 0;
    m_pend = '0;
    e_vld = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step();
    int  t, r, a, d;
    bit  acc, want;
    t = int'(cfg_type); r = int'(cfg_rca); a = int'(cfg_addr); d = int'(cfg_data);
    acc = cfg_valid && !m_pend[r];
    e_vld = rd_valid ? 1 : 0;
    if (rd_valid)
      for (int f = 0; f < 6; f++)
        for (int e = 0; e < 16; e++) rdo[f][e] = act[int'(rd_rca)][f][e];
    e_err  = (acc && (t == 7 || (t <= 5 && a >= NENT[t]))) ? 1 : 0;
    e_done = 0;
    for (int i = 0; i < NR; i++) begin
      want = m_pend[i] || (acc && t == 6 && r == i);
      if (want && !rca_busy[i]) begin
        for (int f = 0; f < 6; f++)
          for (int e = 0; e < 16; e++) act[i][f][e] = sh[i][f][e];
        e_done = 1;
        m_pend[i] = 1'b0;
      end else if (want) begin
        m_pend[i] = 1'b1;
      end
    end
    if (acc && t <= 5 && a < NENT[t]) sh[r][t][a] = d % (1 << WID[t]);
  endtask

  function automatic int dut_ent(int f, int e);
    case (f)
      0: return int'(rd_src_addrs[e*5 +: 5]);
      1: return int'(rd_dest_addrs[e*5 +: 5]);
      2: return int'(rd_grid_sel[e*GW +: GW]);
      3: return int'(rd_io_sel[e*IW +: IW]);
      4: return int'(rd_result_sel[e*RW +: RW]);
      default: return int'(rd_io_use);
    endcase
  endfunction

  // Compare process: advance the model on each edge, check just after it.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step();
    #1;
    chk("rd_out_valid", int'(rd_out_valid), e_vld);
    chk("commit_done", int'(commit_done), e_done);
    chk("cfg_err", int'(cfg_err), e_err);
    chk("commit_pending", int'(commit_pending), int'(m_pend));
    chk("cfg_ready", int'(cfg_ready), m_pend[cfg_rca] ? 0 : 1);
    for (int f = 0; f < 6; f++) begin
      int bad_e;
      bad_e = -1;
      for (int e = 0; e < NENT[f]; e++)
        if (bad_e < 0 && dut_ent(f, e) != rdo[f][e]) bad_e = e;
      if (bad_e < 0) chk($sformatf("rd_field%0d", f), 0, 0 + (dut_ent(f, 0) - rdo[f][0]));
      else chk($sformatf("rd_field%0d[%0d]", f, bad_e), dut_ent(f, bad_e), rdo[f][bad_e]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cmd(int t, int r, int a, int d);
    cfg_valid = 1'b1; cfg_type = 3'(t); cfg_rca = 2'(r);
    cfg_addr = 8'(a); cfg_data = 8'(d);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic rd(int r);
    rd_valid = 1'b1; rd_rca = 2'(r);
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle(1);
    chk("lit_reset_rd_out_valid", int'(rd_out_valid), 0);
    chk("lit_reset_pending", int'(commit_pending), 0);
    chk("lit_reset_grid", int'(rd_grid_sel == '0), 1);
    idle(1);
    rst = 1'b1;
    #1 chk("lit_ready_after_reset", int'(cfg_ready), 1);
    @(negedge clk);

    // Read RCA0 after reset
    rd(0);
    chk("lit_rd0_valid", int'(rd_out_valid), 1);
    chk("lit_rd0_src", int'(rd_src_addrs == '0), 1);

    // Grid mux 5 of RCA2 = 3; invisible until commit
    cmd(2, 2, 5, 3);
    rd(2);
    chk("lit_grid5_precommit", int'(rd_grid_sel[5*GW +: GW]), 0);
    cmd(6, 2, 0, 0);
    chk("lit_commit_done_pulse", int'(commit_done), 1);
    rd(2);
    chk("lit_grid5_postcommit", int'(rd_grid_sel[5*GW +: GW]), 3);
    chk("lit_commit_done_once", int'(commit_done), 0);

    // Commit RCA1 while busy; RCA3 still writable
    rca_busy = 4'b0010;
    cmd(6, 1, 0, 0);
    chk("lit_pending1", int'(commit_pending), 2);
    cfg_rca = 2'd1;
    #1 chk("lit_ready_stalled", int'(cfg_ready), 0);
    @(negedge clk);
    cmd(0, 3, 0, 7);
    idle(1);
    chk("lit_pending1_held", int'(commit_pending), 2);
    rca_busy = 4'b0000;
    idle(1);
    chk("lit_pending1_clear", int'(commit_pending), 0);
    chk("lit_done_after_busy", int'(commit_done), 1);

    // Illegal commands
    cmd(0, 0, 5, 9);
    chk("lit_err_src_range", int'(cfg_err), 1);
    cmd(7, 1, 0, 0);
    chk("lit_err_reserved", int'(cfg_err), 1);
    idle(1);
    chk("lit_err_clear", int'(cfg_err), 0);

    // Read in the same cycle a pending commit lands
    cmd(1, 0, 1, 8'h1F);
    cmd(6, 0, 0, 0);
    cmd(1, 0, 1, 8'h05);
    rca_busy = 4'b0001;
    cmd(6, 0, 0, 0);
    chk("lit_pending0", int'(commit_pending), 1);
    idle(1);
    rca_busy = 4'b0000;
    rd(0);
    chk("lit_dest1_old", int'(rd_dest_addrs[9:5]), 8'h1F);
    chk("lit_done_on_read", int'(commit_done), 1);
    rd(0);
    chk("lit_dest1_new", int'(rd_dest_addrs[9:5]), 5);

    // Reset while a commit is pending
    rca_busy = 4'b0100;
    cmd(2, 2, 0, 1);
    cmd(6, 2, 0, 0);
    chk("lit_pending2", int'(commit_pending), 4);
    #2 rst = 1'b0;
    #1;
    chk("lit_rst_pending", int'(commit_pending), 0);
    chk("lit_rst_rd_valid", int'(rd_out_valid), 0);
    chk("lit_rst_dest", int'(rd_dest_addrs), 0);
    chk("lit_rst_grid", int'(rd_grid_sel == '0), 1);
    @(negedge clk);
    rca_busy = 4'b0000;
    rst = 1'b1;
    cfg_rca = 2'd2;
    #1 chk("lit_ready_after_midreset", int'(cfg_ready), 1);
    @(negedge clk);
    cmd(6, 2, 0, 0);
    rd(2);
    chk("lit_shadow_cleared", int'(rd_grid_sel == '0), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_type  = 3'($urandom_range(0, 7));
      cfg_rca   = 2'($urandom_range(0, NR-1));
      cfg_addr  = 8'($urandom_range(0, 19));
      cfg_data  = 8'($urandom);
      rd_valid  = $urandom_range(0, 1) == 1;
      rd_rca    = 2'($urandom_range(0, NR-1));
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 3) == 0) rca_busy[i] = ~rca_busy[i];
      @(negedge clk);
    end
    rst = 1'b1;
    cfg_valid = 1'b0;
    rd_valid = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
